hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
//   Control-side counterpart of the EX forwarding muxes and the ID hazard stall mux.
//   Generates ForwardA/ForwardB, Mux_Select_Stall, PC/IF-ID write enables and the IF/ID flush.
//   Keeps an internal shadow pipeline of ID/EX, EX/MEM and MEM/WB register-write metadata.
//   Sits beside the ID stage; its outputs drive the datapath mux selects directly.
// PARAMETERS
//   REG_ADDR_W  5   register specifier width
//   CNT_W       16  width of the saturating stall-cycle counter
// PORTS
//   clk            in   1           rising-edge clock
//   reset          in   1           synchronous, active-high
//   id_valid       in   1           ID holds a real instruction
//   id_rs, id_rt   in   REG_ADDR_W  ID source specifiers
//   id_uses_rs/rt  in   1 each      instruction actually reads rs/rt
//   id_dest        in   REG_ADDR_W  resolved destination (rt/rd/$31)
//   id_reg_write   in   1           decode RegWrite
//   id_mem_read    in   1           decode MemRead (lw)
//   id_jump        in   1           j/jal in ID
//   id_jr          in   1           jr in ID (reads rs in ID)
//   ex_branch_taken in  1           branch resolved taken in EX
//   fwd_a, fwd_b   out  2           0=register file, 1=EX/MEM result, 2=MEM/WB result
//   stall_sel      out  1           1 = zero ID/EX RegWrite/MemWrite (bubble)
//   pc_write       out  1           PC load enable
//   ifid_write     out  1           IF/ID load enable
//   ifid_flush     out  1           clear IF/ID on next edge
//   stall_count    out  CNT_W       total stall cycles, saturating
// BEHAVIOUR
//   Reset: shadow slots invalid; fwd_a=fwd_b=0, stall_sel=0, pc_write=1, ifid_write=1,
//     ifid_flush=0, stall_count=0. Applies on the edge where reset=1, also mid-stall.
//   Shadow slots: IDEX{v,rs,rt,dest,rw,mr}, EXMEM{v,dest,rw,mr}, MEMWB{v,dest,rw}; shift every cycle.
//   IDEX loads the ID fields when id_valid & !stall & !ex_branch_taken; otherwise it loads a bubble (v=0).
//   Forwarding is combinational from the registered slots, so it is valid in the same cycle the
//   instruction is in EX.
//     fwd_a=1 if EXMEM.v&rw&dest!=0&dest==IDEX.rs; else 2 if the same test holds for MEMWB; else 0.
//     fwd_b uses IDEX.rt. EX/MEM takes priority over MEM/WB. $0 is never forwarded.
//   The register file writes before it reads within a cycle, so no WB->ID forwarding is generated.
//   Load-use stall: IDEX.v&mr&dest!=0 and the dest matches id_rs (if uses_rs) or id_rt (if uses_rt).
//     Inserts exactly one bubble.
//   jr stall: id_jr and id_rs!=0 matching the dest of a rw slot in IDEX or EXMEM.
//     Holds until the producer reaches MEM/WB: 2 cycles behind an ALU op, 2 behind a lw.
//   stall = id_valid & (load_use | jr_hazard) & !ex_branch_taken
//     -> stall_sel=1, pc_write=0, ifid_write=0.
//   Flush: ifid_flush = ex_branch_taken | ((id_jump|id_jr) & !stall).
//     A taken branch overrides any stall: pc_write=1, ID is squashed into a bubble, and IF/ID is cleared.
//   Simultaneous taken branch and jump in ID: the branch wins, because the ID instruction is wrong-path.
//   stall_count increments on every cycle with stall=1 and saturates at 2^CNT_W-1.
//   Combinational outputs depend only on the slots and the current ID/EX inputs; there is no comb loop.
// STRUCTURE
//   Shared package pipe_ctrl_pkg: FWD_REG=2'd0, FWD_EX=2'd1, FWD_MEM=2'd2, REG_ZERO=5'd0.
//     The forwarding muxes use the same constants.
//   Sub-module forward_select_unit(src, exmem_*, memwb_* -> sel), instantiated twice (A, B).
//   Shadow slots, stall/flush logic and the counter stay in the top module.
// TESTING
//   1. add $3 then sub $4,$3,$5 back-to-back -> fwd_a=1 for sub in EX, no stall.
//      Same with one nop between -> fwd_a=2.
//   2. lw $2 then add $6,$2,$2 -> one cycle stall_sel=1, pc_write=0, ifid_write=0.
//      Next cycle fwd_a=fwd_b=2, stall_count=1.
//   3. Producers write $0 (rw=1, dest=0), consumer reads $0 -> fwd_a=fwd_b=0, no stall.
//   4. EXMEM and MEMWB both write $7; consumer reads $7 -> fwd_a=1 (priority).
//   5. addi $31 then jr $31 -> 2 stall cycles, then ifid_flush=1 with pc_write=1.
//      lw $31 then jr $31 -> 2 stall cycles.
//   6. Load-use stall coincident with ex_branch_taken=1 -> stall=0, pc_write=1, ifid_flush=1,
//      IDEX bubble. Reset asserted mid-stall -> all outputs at reset values next cycle.
//      CNT_W=2, run 5 stalls -> stall_count=3.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control constants.
// The EX forwarding muxes and the hazard/forward control use the same select encoding.
package pipe_ctrl_pkg;

    localparam int unsigned FWD_SEL_W = 2;

    // Forwarding mux selects
    localparam logic [FWD_SEL_W-1:0] FWD_REG = 2'd0;   // register file operand
    localparam logic [FWD_SEL_W-1:0] FWD_EX  = 2'd1;   // EX/MEM result
    localparam logic [FWD_SEL_W-1:0] FWD_MEM = 2'd2;   // MEM/WB result

    // Hard-wired zero register specifier
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/forward_select_unit.sv
// Forward select for one EX operand.
// Ports:
//   src                      operand specifier of the instruction in EX
//   exmem_v/rw/dest          EX/MEM shadow slot metadata
//   memwb_v/rw/dest          MEM/WB shadow slot metadata
//   sel                      forwarding mux select (combinational)
module forward_select_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  exmem_v,
    input  logic                  exmem_rw,
    input  logic [REG_ADDR_W-1:0] exmem_dest,
    input  logic                  memwb_v,
    input  logic                  memwb_rw,
    input  logic [REG_ADDR_W-1:0] memwb_dest,
    output logic [FWD_SEL_W-1:0]  sel
);

    logic w_exmem_hit;
    logic w_memwb_hit;

    // $0 is never a forwarding source
    assign w_exmem_hit = exmem_v && exmem_rw
                      && (exmem_dest != REG_ADDR_W'(REG_ZERO))
                      && (exmem_dest == src);
    assign w_memwb_hit = memwb_v && memwb_rw
                      && (memwb_dest != REG_ADDR_W'(REG_ZERO))
                      && (memwb_dest == src);

    // Youngest producer (EX/MEM) wins
    always_comb begin
        sel = FWD_REG;
        if (w_exmem_hit) begin
            sel = FWD_EX;
        end else if (w_memwb_hit) begin
            sel = FWD_MEM;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding control beside the ID stage.
// Tracks register-write metadata of the instructions in EX, MEM and WB in a
// shadow pipeline and derives EX forward selects, the ID bubble/stall controls,
// the IF/ID flush and a saturating stall-cycle counter.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   id_*                        decoded fields of the instruction in ID
//   ex_branch_taken             branch in EX resolved taken
//   fwd_a, fwd_b                EX operand forward selects (combinational)
//   stall_sel                   bubble into ID/EX (combinational)
//   pc_write, ifid_write        PC / IF-ID load enables (combinational)
//   ifid_flush                  clear IF/ID on next edge (combinational)
//   stall_count                 registered saturating stall-cycle count
module hazard_forward_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_jump,
    input  logic                  id_jr,
    input  logic                  ex_branch_taken,
    output logic [FWD_SEL_W-1:0]  fwd_a,
    output logic [FWD_SEL_W-1:0]  fwd_b,
    output logic                  stall_sel,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(REG_ZERO);

    // ID/EX shadow slot
    logic                  r_idex_v;
    logic [REG_ADDR_W-1:0] r_idex_rs;
    logic [REG_ADDR_W-1:0] r_idex_rt;
    logic [REG_ADDR_W-1:0] r_idex_dest;
    logic                  r_idex_rw;
    logic                  r_idex_mr;
    // EX/MEM shadow slot
    logic                  r_exmem_v;
    logic [REG_ADDR_W-1:0] r_exmem_dest;
    logic                  r_exmem_rw;
    logic                  r_exmem_mr;
    // MEM/WB shadow slot
    logic                  r_memwb_v;
    logic [REG_ADDR_W-1:0] r_memwb_dest;
    logic                  r_memwb_rw;

    logic [CNT_W-1:0]      r_stall_count;

    logic w_load_use;
    logic w_jr_hazard;
    logic w_stall;
    logic w_idex_load;

    // A load in EX whose result the ID instruction needs
    assign w_load_use = r_idex_v && r_idex_mr && (r_idex_dest != ZERO_REG)
                     && ((id_uses_rs && (r_idex_dest == id_rs))
                      || (id_uses_rt && (r_idex_dest == id_rt)));

    // jr reads rs in ID, so it waits until its producer reaches MEM/WB
    assign w_jr_hazard = id_jr && (id_rs != ZERO_REG)
                      && ((r_idex_v  && r_idex_rw  && (r_idex_dest  == id_rs))
                       || (r_exmem_v && r_exmem_rw && (r_exmem_dest == id_rs)));

    // A taken branch squashes ID, so it also cancels any stall
    assign w_stall     = id_valid && (w_load_use || w_jr_hazard) && !ex_branch_taken;
    assign w_idex_load = id_valid && !w_stall && !ex_branch_taken;

    // Stall, enable and flush controls
    always_comb begin
        stall_sel  = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        if (w_stall) begin
            stall_sel  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end
        if (ex_branch_taken || ((id_jump || id_jr) && !w_stall)) begin
            ifid_flush = 1'b1;
        end
    end

    // Shadow pipeline: shifts every cycle, ID/EX takes a bubble when not loading
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idex_v     <= 1'b0;
            r_idex_rs    <= '0;
            r_idex_rt    <= '0;
            r_idex_dest  <= '0;
            r_idex_rw    <= 1'b0;
            r_idex_mr    <= 1'b0;
            r_exmem_v    <= 1'b0;
            r_exmem_dest <= '0;
            r_exmem_rw   <= 1'b0;
            r_exmem_mr   <= 1'b0;
            r_memwb_v    <= 1'b0;
            r_memwb_dest <= '0;
            r_memwb_rw   <= 1'b0;
        end else begin
            r_idex_v     <= w_idex_load;
            r_idex_rs    <= id_rs;
            r_idex_rt    <= id_rt;
            r_idex_dest  <= id_dest;
            r_idex_rw    <= id_reg_write && w_idex_load;
            r_idex_mr    <= id_mem_read && w_idex_load;
            r_exmem_v    <= r_idex_v;
            r_exmem_dest <= r_idex_dest;
            r_exmem_rw   <= r_idex_rw;
            r_exmem_mr   <= r_idex_mr;
            r_memwb_v    <= r_exmem_v;
            r_memwb_dest <= r_exmem_dest;
            r_memwb_rw   <= r_exmem_rw;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign stall_count = r_stall_count;

    // Load-data forwarding from EX/MEM is harmless: load-use stalls keep a
    // consumer out of EX while its load sits in EX/MEM.
    logic w_unused;
    assign w_unused = r_exmem_mr;

    forward_select_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_a (
        .src        (r_idex_rs),
        .exmem_v    (r_exmem_v),
        .exmem_rw   (r_exmem_rw),
        .exmem_dest (r_exmem_dest),
        .memwb_v    (r_memwb_v),
        .memwb_rw   (r_memwb_rw),
        .memwb_dest (r_memwb_dest),
        .sel        (fwd_a)
    );

    forward_select_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_b (
        .src        (r_idex_rt),
        .exmem_v    (r_exmem_v),
        .exmem_rw   (r_exmem_rw),
        .exmem_dest (r_exmem_dest),
        .memwb_v    (r_memwb_v),
        .memwb_rw   (r_memwb_rw),
        .memwb_dest (r_memwb_dest),
        .sel        (fwd_b)
    );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit; a second instance with a 2-bit
// counter shares the stimulus to exercise counter saturation.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       id_uses_rs = 1'b0;
    logic       id_uses_rt = 1'b0;
    logic [4:0] id_dest = '0;
    logic       id_reg_write = 1'b0;
    logic       id_mem_read = 1'b0;
    logic       id_jump = 1'b0;
    logic       id_jr = 1'b0;
    logic       ex_branch_taken = 1'b0;

    logic [1:0]  fwd_a, fwd_b, fwd_a2, fwd_b2;
    logic        stall_sel, pc_write, ifid_write, ifid_flush;
    logic        stall_sel2, pc_write2, ifid_write2, ifid_flush2;
    logic [15:0] stall_count;
    logic [1:0]  stall_count2;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_jump(id_jump),
        .id_jr(id_jr), .ex_branch_taken(ex_branch_taken), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_sel(stall_sel), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .stall_count(stall_count)
    );

    hazard_forward_unit #(.REG_ADDR_W(5), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_jump(id_jump),
        .id_jr(id_jr), .ex_branch_taken(ex_branch_taken), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
        .stall_sel(stall_sel2), .pc_write(pc_write2), .ifid_write(ifid_write2),
        .ifid_flush(ifid_flush2), .stall_count(stall_count2)
    );

    // Advance one clock; inputs change 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the ID-stage instruction and let combinational outputs settle
    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic [4:0] dest,
                          input logic rw, input logic mr, input logic jmp, input logic jr);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_dest = dest; id_reg_write = rw; id_mem_read = mr; id_jump = jmp; id_jr = jr;
        #1;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        nop();
        ex_branch_taken = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        nop();
        tick(); tick();
        reset = 1'b0;
        #1;
        total++; if (fwd_a !== 2'd0) begin bad++; $display("FAIL reset_fwd_a: got %0d want 0", fwd_a); end
        total++; if (fwd_b !== 2'd0) begin bad++; $display("FAIL reset_fwd_b: got %0d want 0", fwd_b); end
        total++; if ({stall_sel, pc_write, ifid_write, ifid_flush} !== 4'b0110) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0110", {stall_sel, pc_write, ifid_write, ifid_flush}); end
        total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", stall_count); end
    endtask

    task automatic test_fwd_alu();
        // add $3,$1,$2 ; sub $4,$3,$5
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0);
        tick();
        set_id(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0, 0);
        total++; if (stall_sel !== 1'b0) begin bad++; $display("FAIL alu_nostall: got %0d want 0", stall_sel); end
        tick();
        nop();
        total++; if (fwd_a !== 2'd1) begin bad++; $display("FAIL alu_fwd_ex_a: got %0d want 1", fwd_a); end
        total++; if (fwd_b !== 2'd0) begin bad++; $display("FAIL alu_fwd_ex_b: got %0d want 0", fwd_b); end
        drain();
        // add $3 ; nop ; sub $4,$3,$5
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0);
        tick();
        nop();
        tick();
        set_id(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0, 0);
        tick();
        nop();
        total++; if (fwd_a !== 2'd2) begin bad++; $display("FAIL alu_fwd_mem_a: got %0d want 2", fwd_a); end
        drain();
    endtask

    task automatic test_load_use();
        // lw $2,0($1) ; add $6,$2,$2
        set_id(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0, 0);
        tick();
        set_id(1, 5'd2, 5'd2, 1, 1, 5'd6, 1, 0, 0, 0);
        total++; if ({stall_sel, pc_write, ifid_write} !== 3'b100) begin
            bad++; $display("FAIL lu_stall: got %b want 100", {stall_sel, pc_write, ifid_write}); end
        tick();
        exp_cnt++;
        total++; if ({stall_sel, pc_write, ifid_write} !== 3'b011) begin
            bad++; $display("FAIL lu_release: got %b want 011", {stall_sel, pc_write, ifid_write}); end
        total++; if (stall_count !== 16'(exp_cnt)) begin bad++; $display("FAIL lu_cnt: got %0d want %0d", stall_count, exp_cnt); end
        tick();
        nop();
        total++; if ({fwd_a, fwd_b} !== 4'b1010) begin bad++; $display("FAIL lu_fwd: got a=%0d b=%0d want 2 2", fwd_a, fwd_b); end
        drain();
    endtask

    task automatic test_zero_reg();
        // lw $0 ; add $0,$0,$1 ; add $8,$0,$0
        set_id(1, 5'd1, 5'd1, 1, 0, 5'd0, 1, 1, 0, 0);
        tick();
        set_id(1, 5'd0, 5'd1, 1, 1, 5'd0, 1, 0, 0, 0);
        total++; if (stall_sel !== 1'b0) begin bad++; $display("FAIL zero_nostall: got %0d want 0", stall_sel); end
        tick();
        set_id(1, 5'd0, 5'd0, 1, 1, 5'd8, 1, 0, 0, 0);
        tick();
        nop();
        total++; if ({fwd_a, fwd_b} !== 4'b0000) begin bad++; $display("FAIL zero_fwd: got a=%0d b=%0d want 0 0", fwd_a, fwd_b); end
        drain();
    endtask

    task automatic test_priority();
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0, 0, 0);
        tick();
        set_id(1, 5'd3, 5'd4, 1, 1, 5'd7, 1, 0, 0, 0);
        tick();
        set_id(1, 5'd7, 5'd7, 1, 1, 5'd9, 1, 0, 0, 0);
        tick();
        nop();
        total++; if ({fwd_a, fwd_b} !== 4'b0101) begin bad++; $display("FAIL prio_fwd: got a=%0d b=%0d want 1 1", fwd_a, fwd_b); end
        drain();
    endtask

    task automatic test_jr(input logic load, input string tag);
        // addi $31,$0,4 (or lw $31) ; jr $31
        set_id(1, 5'd0, 5'd0, 1, 0, 5'd31, 1, load, 0, 0);
        tick();
        set_id(1, 5'd31, 5'd0, 1, 0, 5'd0, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            total++; if ({stall_sel, pc_write, ifid_flush} !== 3'b100) begin
                bad++; $display("FAIL %s_stall%0d: got %b want 100", tag, i, {stall_sel, pc_write, ifid_flush}); end
            tick();
            exp_cnt++;
        end
        total++; if ({stall_sel, pc_write, ifid_flush} !== 3'b011) begin
            bad++; $display("FAIL %s_go: got %b want 011", tag, {stall_sel, pc_write, ifid_flush}); end
        total++; if (stall_count !== 16'(exp_cnt)) begin bad++; $display("FAIL %s_cnt: got %0d want %0d", tag, stall_count, exp_cnt); end
        tick();
        drain();
    endtask

    task automatic test_branch();
        // lw $2 ; lw $9,0($2) in ID while branch taken -> squashed
        set_id(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0, 0);
        tick();
        ex_branch_taken = 1'b1;
        set_id(1, 5'd2, 5'd0, 1, 0, 5'd9, 1, 1, 0, 0);
        total++; if ({stall_sel, pc_write, ifid_write, ifid_flush} !== 4'b0111) begin
            bad++; $display("FAIL br_override: got %b want 0111", {stall_sel, pc_write, ifid_write, ifid_flush}); end
        tick();
        ex_branch_taken = 1'b0;
        // consumer of $9: a squashed lw must not cause a load-use stall
        set_id(1, 5'd9, 5'd0, 1, 0, 5'd10, 1, 0, 0, 0);
        total++; if (stall_sel !== 1'b0) begin bad++; $display("FAIL br_bubble: got %0d want 0", stall_sel); end
        total++; if (stall_count !== 16'(exp_cnt)) begin bad++; $display("FAIL br_cnt: got %0d want %0d", stall_count, exp_cnt); end
        tick();
        // taken branch coincident with a jump in ID
        ex_branch_taken = 1'b1;
        set_id(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        total++; if ({pc_write, ifid_flush} !== 2'b11) begin
            bad++; $display("FAIL br_jump: got %b want 11", {pc_write, ifid_flush}); end
        tick();
        drain();
    endtask

    task automatic test_reset_mid_stall();
        set_id(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0, 0);
        tick();
        set_id(1, 5'd2, 5'd2, 1, 1, 5'd6, 1, 0, 0, 0);
        total++; if (stall_sel !== 1'b1) begin bad++; $display("FAIL rst_pre_stall: got %0d want 1", stall_sel); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        exp_cnt = 0;
        total++; if ({fwd_a, fwd_b, stall_sel, pc_write, ifid_write, ifid_flush} !== 8'b0000_0110) begin
            bad++; $display("FAIL rst_mid: got %b want 00000110", {fwd_a, fwd_b, stall_sel, pc_write, ifid_write, ifid_flush}); end
        total++; if ({stall_count, stall_count2} !== 18'd0) begin
            bad++; $display("FAIL rst_mid_cnt: got %0d/%0d want 0/0", stall_count, stall_count2); end
        drain();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 5; i++) begin
            set_id(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0, 0);
            tick();
            set_id(1, 5'd2, 5'd3, 1, 1, 5'd6, 1, 0, 0, 0);
            tick();
            exp_cnt++;
            tick();
            drain();
        end
        total++; if (stall_count2 !== 2'd3) begin bad++; $display("FAIL sat_cnt2: got %0d want 3", stall_count2); end
        total++; if (stall_count !== 16'(exp_cnt)) begin bad++; $display("FAIL sat_cnt16: got %0d want %0d", stall_count, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_fwd_alu();
        test_load_use();
        test_zero_reg();
        test_priority();
        test_jr(1'b0, "jr_alu");
        test_jr(1'b1, "jr_lw");
        test_branch();
        test_reset_mid_stall();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
